// File: rtl/prod_accum_pkg.sv
// Shared types and constants for the product accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional feature macro used by the block: PROD_ACCUM_SATURATE_EN.
package prod_accum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int N_DEF     = 8;
    localparam int LEN_DEF   = 16;
    localparam int ACC_W_DEF = 2 * N_DEF + 4;

    // Ceiling log2; clog2(1) is 0, callers clamp where a width of 1 is needed.
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/acc_adder.sv
// ACC_W-bit unsigned add of accumulator and product with carry-out (overflow event).
// Latency: combinational, no state.
// Backpressure: none; macro PROD_ACCUM_SATURATE_EN clamps to all-ones on carry instead of wrapping.
module acc_adder
    import prod_accum_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int P_W   = 2 * N_DEF
) (
    input  logic [ACC_W-1:0] acc_in,
    input  logic [P_W-1:0]   term,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

    logic [ACC_W-1:0] term_w;
    logic             dropped;
    logic [ACC_W:0]   raw;

    // A product wider than the accumulator is truncated; any lost high bit counts as overflow.
    generate
        if (P_W > ACC_W) begin : g_trunc
            assign term_w  = term[ACC_W-1:0];
            assign dropped = |term[P_W-1:ACC_W];
        end else begin : g_ext
            assign term_w  = ACC_W'(term);
            assign dropped = 1'b0;
        end
    endgenerate

    assign raw   = {1'b0, acc_in} + {1'b0, term_w};
    assign carry = raw[ACC_W] | dropped;

`ifdef PROD_ACCUM_SATURATE_EN
    // Once clamped, any further nonzero term carries again, so the value stays pinned.
    assign sum = carry ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
    assign sum = raw[ACC_W-1:0];
`endif

endmodule

// File: rtl/prod_accum.sv
// Accumulates LEN unsigned multiplier products into a dot-product result with sticky overflow.
// Latency: LEN+1 cycles from start to out_valid at full input rate; one term per cycle.
// Backpressure: in_ready is a pure state decode; result/ovf held in DONE until out_ready (PROD_ACCUM_SATURATE_EN selects clamp vs wrap).
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int n     = N_DEF,
    parameter int LEN   = LEN_DEF,
    parameter int ACC_W = 2 * n + 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*n-1:0]   product,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             ovf
);

    localparam int              CNT_W        = (clog2(LEN) < 1) ? 1 : clog2(LEN);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(LEN - 1);
    // When the accumulator is wide enough for LEN full-scale products, overflow cannot occur.
    localparam bit              OVF_POSSIBLE = (ACC_W < 2 * n + clog2(LEN));

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_carry;
    logic             take;

    acc_adder #(
        .ACC_W (ACC_W),
        .P_W   (2 * n)
    ) u_adder (
        .acc_in (acc_q),
        .term   (product),
        .sum    (add_sum),
        .carry  (add_carry)
    );

    assign take = in_valid && (state_q == ST_ACC);

    // Next-state, accumulator, counter and sticky overflow.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_ACC: begin
                if (take) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | (OVF_POSSIBLE & add_carry);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (start) begin
                        // Chain straight into the next dot-product without an idle cycle.
                        state_d = ST_ACC;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards any partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = acc_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_prod_accum.sv
// Self-checking bench: two accumulators (18-bit, no overflow; 16-bit, overflow) on shared stimulus.
// Latency: checks LEN+1 start-to-result timing including input bubbles.
// Backpressure: exercises out_ready stalls, back-to-back chaining and mid-sequence reset.
module tb_prod_accum;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [15:0] product;
    logic        out_ready;

    logic        in_ready_a, busy_a, out_valid_a, ovf_a;
    logic [17:0] result_a;
    logic        in_ready_b, busy_b, out_valid_b, ovf_b;
    logic [15:0] result_b;

    int n_checks = 0;
    int n_err    = 0;
    bit chain_pending = 1'b0;

    prod_accum #(.n(8), .LEN(4), .ACC_W(18)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
        .product(product), .busy(busy_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .result(result_a), .ovf(ovf_a)
    );

    prod_accum #(.n(8), .LEN(4), .ACC_W(16)) u_ovf (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
        .product(product), .busy(busy_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .result(result_b), .ovf(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][15:0] t;
        int               gap;
        int               bp;
        bit               chain;
        logic [31:0]      r18;
        bit               o18;
        logic [31:0]      r16;
        bit               o16;
    } vec_t;

    vec_t vecs[5];

`ifdef PROD_ACCUM_SATURATE_EN
    localparam logic [31:0] R16_FULL = 32'd65535;
    localparam logic [31:0] R16_TWO  = 32'd65535;
`else
    localparam logic [31:0] R16_FULL = 32'd63492;
    localparam logic [31:0] R16_TWO  = 32'd65534;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: the whole-sequence sum, then wrapped or clamped to w bits.
    function automatic void model(input logic [3:0][15:0] t, input int w,
                                  output logic [31:0] res, output bit ov);
        longint total;
        longint maxv;
        total = 0;
        for (int i = 0; i < 4; i++) total += longint'(t[i]);
        maxv = (longint'(1) << w) - 1;
        ov = (total > maxv);
`ifdef PROD_ACCUM_SATURATE_EN
        res = ov ? 32'(maxv) : 32'(total);
`else
        res = 32'(total & maxv);
`endif
    endfunction

    function automatic vec_t mk(input logic [15:0] t0, input logic [15:0] t1, input logic [15:0] t2,
                                input logic [15:0] t3, input int gap, input int bp, input bit chain,
                                input logic [31:0] r18, input bit o18, input logic [31:0] r16, input bit o16);
        vec_t v;
        v.t = {t3, t2, t1, t0};
        v.gap = gap; v.bp = bp; v.chain = chain;
        v.r18 = r18; v.o18 = o18; v.r16 = r16; v.o16 = o16;
        return v;
    endfunction

    // One dot-product; entered and left at a falling edge.
    task automatic run_seq(input logic [3:0][15:0] t, input int gap, input int bp, input bit chain,
                           input logic [31:0] r18, input bit o18, input logic [31:0] r16, input bit o16);
        int cyc;
        if (!chain_pending) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b0;
        cyc = 1;
        check("start_to_acc", {28'd0, in_ready_a, in_ready_b, busy_a, out_valid_a}, 32'b1110);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            product = t[i];
            @(negedge clk);
            cyc++;
            in_valid = 1'b0;
            if (i < 3) begin
                for (int g = 0; g < gap; g++) begin
                    product = 16'($urandom);
                    start = 1'($urandom);
                    @(negedge clk);
                    cyc++;
                end
                start = 1'b0;
            end
        end
        while (!out_valid_a && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, 32'(5 + 3 * gap));
        check("done_flags", {27'd0, out_valid_a, out_valid_b, in_ready_a, in_ready_b, busy_a}, 32'b11001);
        check("result18", {14'd0, result_a}, r18);
        check("ovf18", {31'd0, ovf_a}, {31'd0, o18});
        check("result16", {16'd0, result_b}, r16);
        check("ovf16", {31'd0, ovf_b}, {31'd0, o16});
        for (int k = 0; k < bp; k++) begin
            product = 16'($urandom);
            @(negedge clk);
            check("hold18", {12'd0, out_valid_a, in_ready_a, ovf_a, result_a}, {12'd0, 1'b1, 1'b0, o18, r18[17:0]});
            check("hold16", {14'd0, out_valid_b, ovf_b, result_b}, {14'd0, 1'b1, o16, r16[15:0]});
        end
        out_ready = 1'b1;
        start = chain;
        chain_pending = chain;
        if (!chain) begin
            @(negedge clk);
            out_ready = 1'b0;
            check("to_idle", {28'd0, out_valid_a, busy_a, in_ready_a, busy_b}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0][15:0] rt;
        logic [31:0] m18, m16;
        bit mo18, mo16;
        int rg, rb;
        bit rc;

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; product = 16'd0; out_ready = 1'b0;

        vecs[0] = mk(16'd65025, 16'd65025, 16'd65025, 16'd65025, 0, 0, 1'b1, 32'd260100, 1'b0, R16_FULL, 1'b1);
        vecs[1] = mk(16'd5, 16'd5, 16'd5, 16'd5, 0, 1, 1'b0, 32'd20, 1'b0, 32'd20, 1'b0);
        vecs[2] = mk(16'd1, 16'd2, 16'd3, 16'd4, 2, 5, 1'b0, 32'd10, 1'b0, 32'd10, 1'b0);
        vecs[3] = mk(16'd65535, 16'd65535, 16'd0, 16'd0, 1, 0, 1'b1, 32'd131070, 1'b0, R16_TWO, 1'b1);
        vecs[4] = mk(16'd0, 16'd0, 16'd0, 16'd0, 0, 2, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);

        repeat (3) @(negedge clk);
        check("reset_a", {12'd0, in_ready_a, busy_a, out_valid_a, ovf_a, result_a}, 32'd0);
        check("reset_b", {12'd0, in_ready_b, busy_b, out_valid_b, ovf_b, result_b}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_start_low", {29'd0, in_ready_a, busy_a, out_valid_a}, 32'd0);

        for (int v = 0; v < 5; v++) begin
            run_seq(vecs[v].t, vecs[v].gap, vecs[v].bp, vecs[v].chain,
                    vecs[v].r18, vecs[v].o18, vecs[v].r16, vecs[v].o16);
        end

        // Reset in the middle of a sequence, after two accepted terms.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; product = 16'd7;
        @(negedge clk);
        product = 16'd9;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_reset_sum", {14'd0, result_a}, 32'd16);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_a", {12'd0, in_ready_a, busy_a, out_valid_a, ovf_a, result_a}, 32'd0);
        check("midrst_b", {12'd0, in_ready_b, busy_b, out_valid_b, ovf_b, result_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chain_pending = 1'b0;
        run_seq({16'd1, 16'd1, 16'd1, 16'd1}, 0, 0, 1'b0, 32'd4, 1'b0, 32'd4, 1'b0);

        // Random sequences against the reference model.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 4; i++) rt[i] = 16'($urandom);
            rg = $urandom_range(0, 2);
            rb = $urandom_range(0, 3);
            rc = (r == 19) ? 1'b0 : 1'($urandom);
            model(rt, 18, m18, mo18);
            model(rt, 16, m16, mo16);
            run_seq(rt, rg, rb, rc, m18, mo18, m16, mo16);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
